// File: rtl/pdes_pkg.sv
// Shared types and defaults for the event dispatcher: FSM state enum, default sizes
// and the core-index width helper.
package pdes_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NUM_CORES = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } evt_state_e;

  function automatic int core_bits(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/evt_dispatch_if.sv
// FIFO pop side plus core issue/ack/done handshake of the dispatcher.
// master = dispatcher, slave = FIFO/core environment.
interface evt_dispatch_if
  import pdes_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int CORE_BITS = core_bits(NUM_CORES)
);
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_dout;
  logic                 fifo_rd_en;
  logic                 evt_valid;
  logic [WIDTH-1:0]     evt_data;
  logic [CORE_BITS-1:0] evt_core;
  logic                 evt_ack;
  logic [NUM_CORES-1:0] core_done;

  modport master (
    input  fifo_empty, fifo_dout, evt_ack, core_done,
    output fifo_rd_en, evt_valid, evt_data, evt_core
  );

  modport slave (
    output fifo_empty, fifo_dout, evt_ack, core_done,
    input  fifo_rd_en, evt_valid, evt_data, evt_core
  );
endinterface

// File: rtl/evt_dispatch_rr_arbiter.sv
// Rotate-priority encoder: first requesting index at or above ptr_i, wrapping
// modulo NUM_CORES.
module rr_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int CORE_BITS = 3
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [CORE_BITS-1:0] ptr_i,
  output logic [CORE_BITS-1:0] grant_o,
  output logic                 grant_vld_o
);

  logic [CORE_BITS-1:0] idx;

  function automatic logic [CORE_BITS-1:0] wrap_idx(int s);
    return (s >= NUM_CORES) ? CORE_BITS'(s - NUM_CORES) : CORE_BITS'(s);
  endfunction

  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = wrap_idx(int'(ptr_i) + k);
      if (!grant_vld_o && req_i[idx]) begin
        grant_vld_o = 1'b1;
        grant_o     = idx;
      end
    end
  end

endmodule

// File: rtl/evt_dispatch.sv
// Pops events from an FWFT FIFO and issues them round-robin to idle cores, tracking
// per-core busy state. Optional stall counter: EVT_DISPATCH_STALL_CNT_EN.
module evt_dispatch
  import pdes_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int CORE_BITS = core_bits(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  evt_dispatch_if.master       bus,
  output logic [NUM_CORES-1:0] busy_mask_o,
  output logic [31:0]          disp_count_o
`ifdef EVT_DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0]          stall_count_o
`endif
);

  evt_state_e           state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CORE_BITS-1:0] core_q, core_d;
  logic [CORE_BITS-1:0] rr_q, rr_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [31:0]          disp_q, disp_d;

  logic                 ack_fire, load, grant_vld;
  logic [NUM_CORES-1:0] ack_oh, req;
  logic [CORE_BITS-1:0] grant;

  assign ack_fire = (state_q == SEND) && bus.evt_ack;
  // The core being acked becomes busy at this edge, so it cannot take the next event.
  assign ack_oh   = ack_fire ? (NUM_CORES'(1) << core_q) : '0;
  assign req      = ~busy_q & ~ack_oh;

  rr_arbiter #(.NUM_CORES(NUM_CORES), .CORE_BITS(CORE_BITS)) u_arb (
    .req_i       (req),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_vld_o (grant_vld)
  );

  assign load = !rst && !bus.fifo_empty && grant_vld && (state_q == IDLE || ack_fire);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    core_d  = core_q;
    rr_d    = rr_q;
    busy_d  = busy_q & ~bus.core_done;
    disp_d  = disp_q;
    if (ack_fire) begin
      busy_d[core_q] = 1'b1;
      disp_d         = disp_q + 32'd1;
    end
    if (load) begin
      state_d = SEND;
      data_d  = bus.fifo_dout;
      core_d  = grant;
      rr_d    = (grant == CORE_BITS'(NUM_CORES - 1)) ? '0 : grant + CORE_BITS'(1);
    end else if (ack_fire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      core_q  <= '0;
      rr_q    <= '0;
      busy_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      core_q  <= core_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.fifo_rd_en = load;
  assign bus.evt_valid  = (state_q == SEND);
  assign bus.evt_data   = data_q;
  assign bus.evt_core   = core_q;
  assign busy_mask_o    = busy_q;
  assign disp_count_o   = disp_q;

`ifdef EVT_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_d = (!bus.fifo_empty && &busy_q) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_evt_dispatch.sv
// Directed + randomized bench for evt_dispatch against a cycle-level behavioural model.
module tb_evt_dispatch;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int CB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  evt_dispatch_if #(.WIDTH(W), .NUM_CORES(N), .CORE_BITS(CB)) bus ();
  logic [N-1:0] busy_mask;
  logic [31:0]  disp_count;
`ifdef EVT_DISPATCH_STALL_CNT_EN
  logic [31:0]  stall_count;
`endif

  evt_dispatch #(.WIDTH(W), .NUM_CORES(N), .CORE_BITS(CB)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy_mask_o  (busy_mask),
    .disp_count_o (disp_count)
`ifdef EVT_DISPATCH_STALL_CNT_EN
    ,
    .stall_count_o(stall_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int rd_cnt;

  // Behavioural model
  logic [W-1:0] fifo[$];
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_core;
  logic [N-1:0] m_busy;
  int           m_rr;
  logic [31:0]  m_disp;
  logic [31:0]  m_stall;
  bit           ack;
  logic [N-1:0] done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_data = '0; m_core = 0; m_busy = '0;
    m_rr = 0; m_disp = '0; m_stall = '0;
  endtask

  // First idle core scanning upward from the round-robin pointer; -1 if none.
  function automatic int m_grant(bit ackf);
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (!m_busy[i] && !(ackf && i == m_core)) return i;
    end
    return -1;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, bus.evt_valid, m_valid);
    chk({tag, ".busy"},  busy_mask, m_busy);
    chk({tag, ".disp"},  disp_count, m_disp);
    if (m_valid) begin
      chk({tag, ".data"}, bus.evt_data, m_data);
      chk({tag, ".core"}, bus.evt_core, m_core);
    end
`ifdef EVT_DISPATCH_STALL_CNT_EN
    chk({tag, ".stall"}, stall_count, m_stall);
`endif
  endtask

  // One clock: called just after a falling edge with ack/done set by the caller.
  task automatic step(input string tag);
    bit ackf, exp_rd;
    int g;
    bus.fifo_empty = (fifo.size() == 0);
    bus.fifo_dout  = (fifo.size() != 0) ? fifo[0] : '0;
    bus.evt_ack    = ack;
    bus.core_done  = done;
    #1;
    ackf   = m_valid && ack;
    g      = m_grant(ackf);
    exp_rd = (fifo.size() != 0) && (g >= 0) && (!m_valid || ackf);
    chk({tag, ".rd_en"}, bus.fifo_rd_en, exp_rd);
    if (bus.fifo_rd_en === 1'b1) rd_cnt++;
    if (fifo.size() != 0 && &m_busy) m_stall++;
    m_busy = m_busy & ~done;
    if (ackf) begin
      m_busy[m_core] = 1'b1;
      m_disp++;
    end
    if (exp_rd) begin
      m_valid = 1;
      m_data  = fifo.pop_front();
      m_core  = g;
      m_rr    = (g + 1) % N;
    end else if (ackf) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outs(tag);
    done = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack = 0; done = '0;
    bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.evt_ack = 1'b0; bus.core_done = '0;
    fifo.delete();
    m_reset();
    rd_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst.valid", bus.evt_valid, 1'b0);
    chk("rst.data",  bus.evt_data, 32'h0);
    chk("rst.core",  bus.evt_core, 3'd0);
    chk("rst.busy",  busy_mask, 8'h00);
    chk("rst.disp",  disp_count, 32'h0);
    chk("rst.rd_en", bus.fifo_rd_en, 1'b0);

    // 1: single event, ack on the second SEND cycle
    fifo.push_back(32'hA5A5_0001);
    ack = 0; step("t1.pop");
    ack = 0; step("t1.wait");
    ack = 1; step("t1.ack");
    ack = 0; step("t1.idle");
    chk("t1.rd_pulses", rd_cnt, 1);
    chk("t1.core", bus.evt_core, 3'd0);
    chk("t1.busy", busy_mask, 8'h01);
    chk("t1.disp", disp_count, 32'd1);

    // 2: back-to-back with ack held high
    do_reset();
    for (int i = 0; i < 4; i++) fifo.push_back(32'h2000_0000 + i);
    ack = 1;
    for (int i = 0; i < 6; i++) step("t2");
    chk("t2.rd_pulses", rd_cnt, 4);
    chk("t2.busy", busy_mask, 8'h0F);
    chk("t2.disp", disp_count, 32'd4);

    // 3: all busy stalls the FIFO; a done frees core 5
    do_reset();
    for (int i = 0; i < 9; i++) fifo.push_back(32'h3000_0000 + i);
    ack = 1;
    for (int i = 0; i < 9; i++) step("t3.fill");
    ack = 0;
    for (int i = 0; i < 10; i++) step("t3.stall");
    chk("t3.rd_en", bus.fifo_rd_en, 1'b0);
    chk("t3.valid", bus.evt_valid, 1'b0);
`ifdef EVT_DISPATCH_STALL_CNT_EN
    chk("t3.stall10", stall_count, 32'd10);
`endif
    done = 8'h20; step("t3.done5");
    step("t3.reissue");
    chk("t3.core5", bus.evt_core, 3'd5);
    chk("t3.valid5", bus.evt_valid, 1'b1);

    // 4: round-robin wrap with busy=0x81 and pointer at 7
    do_reset();
    for (int i = 0; i < 8; i++) fifo.push_back(32'h4000_0000 + i);
    ack = 1;
    for (int i = 0; i < 9; i++) step("t4.a");
    done = 8'h7F; step("t4.free");
    for (int i = 0; i < 7; i++) fifo.push_back(32'h4100_0000 + i);
    for (int i = 0; i < 8; i++) step("t4.b");
    ack = 0;
    done = 8'h7E; step("t4.free2");
    chk("t4.busy81", busy_mask, 8'h81);
    fifo.push_back(32'h4200_0001);
    fifo.push_back(32'h4200_0002);
    step("t4.g1");
    chk("t4.grant1", bus.evt_core, 3'd1);
    ack = 1; step("t4.g2");
    chk("t4.grant2", bus.evt_core, 3'd2);

    // 5: same-cycle done and ack on core 3
    do_reset();
    for (int i = 0; i < 4; i++) fifo.push_back(32'h5000_0000 + i);
    ack = 1;
    for (int i = 0; i < 4; i++) step("t5.a");
    done = 8'h08; step("t5.same");
    chk("t5.busy3", busy_mask[3], 1'b1);
    chk("t5.busy", busy_mask, 8'h0F);

    // 6: async reset while an event is held without ack
    do_reset();
    fifo.push_back(32'h6000_000A);
    fifo.push_back(32'h6000_000B);
    fifo.push_back(32'h6000_000C);
    ack = 1; step("t6.a");
    step("t6.b");
    ack = 0; step("t6.hold");
    #2 rst = 1'b1;
    #1;
    chk("t6.valid", bus.evt_valid, 1'b0);
    chk("t6.busy",  busy_mask, 8'h00);
    chk("t6.disp",  disp_count, 32'h0);
    chk("t6.data",  bus.evt_data, 32'h0);
    chk("t6.core",  bus.evt_core, 3'd0);
    m_reset();
    bus.fifo_empty = 1'b0;
    bus.fifo_dout  = fifo[0];
    #1;
    chk("t6.rd_en_rst", bus.fifo_rd_en, 1'b0);
    @(posedge clk); #1;
    chk("t6.rd_en_rst2", bus.fifo_rd_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("t6.next");
    chk("t6.core0", bus.evt_core, 3'd0);
    chk("t6.dataC", bus.evt_data, 32'h6000_000C);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo.size() < 6) fifo.push_back($urandom);
      ack  = ($urandom_range(0, 3) != 0);
      done = N'($urandom & $urandom & $urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
